uart_tx_streamer: RTL

- Host-side initiator for the UART controller's Tx parallel port.
- Buffers bytes written by a host (CPU bus, command block) into a FIFO.
- Drains the FIFO one character at a time: drives tx_start/tx_data and waits for tx_busy/tx_done from the controller.
- Sits between host logic and uart_controller. Its outputs connect directly to tx_start_i/tx_data_i; tx_busy_o/tx_done_o feed back.

---
 rtl/uart_tx_streamer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_streamer.sv
// uart_tx_streamer
//   Host-side feeder for the UART controller's Tx parallel port. Host bytes are
//   queued in a FIFO. A small FSM pops one byte at a time and presents it on
//   tx_start_o/tx_data_o, then waits for the controller to finish it via
//   tx_busy_i/tx_done_i.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | nothing in flight; launch the head byte when permitted
//   START     | tx_start_o held high, waiting for the controller to react
//   WAIT_DONE | controller is shifting the byte out, waiting for tx_done_i
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   wr_valid_i/wr_data_i  host write; accepted when wr_ready_o is high
//   wr_ready_o            FIFO not full
//   flush_i               drop all queued bytes (the in-flight byte still completes)
//   stream_en_i           allow launching new characters
//   fifo_level_o          occupancy 0..FIFO_DEPTH
//   fifo_empty_o          occupancy is zero
//   fifo_full_o           occupancy is FIFO_DEPTH
//   busy_o                a character is in flight
//   tx_start_o/tx_data_o  to controller tx_start_i/tx_data_i
//   tx_busy_i/tx_done_i   from controller tx_busy_o/tx_done_o

module uart_tx_streamer #(
   parameter int MAX_UART_DATA_W = 8,
   parameter int FIFO_DEPTH      = 16,
   parameter int FIFO_ADDR_W     = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wr_valid_i,
   input  logic [MAX_UART_DATA_W-1:0] wr_data_i,
   output logic                       wr_ready_o,
   input  logic                       flush_i,
   input  logic                       stream_en_i,
   output logic [FIFO_ADDR_W:0]       fifo_level_o,
   output logic                       fifo_empty_o,
   output logic                       fifo_full_o,
   output logic                       busy_o,
   output logic                       tx_start_o,
   output logic [MAX_UART_DATA_W-1:0] tx_data_o,
   input  logic                       tx_busy_i,
   input  logic                       tx_done_i
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   localparam logic [FIFO_ADDR_W:0]   LEVEL_MAX = (FIFO_ADDR_W+1)'(FIFO_DEPTH);
   localparam logic [FIFO_ADDR_W:0]   LEVEL_ONE = {{FIFO_ADDR_W{1'b0}}, 1'b1};
   localparam logic [FIFO_ADDR_W-1:0] PTR_ONE   = {{(FIFO_ADDR_W-1){1'b0}}, 1'b1};

   state_t                       state_q, state_d;
   logic [MAX_UART_DATA_W-1:0]   mem_q [FIFO_DEPTH];
   logic [FIFO_ADDR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [FIFO_ADDR_W:0]         level_q;
   logic                         push, pop;
   logic                         tx_start_q, tx_start_d;
   logic [MAX_UART_DATA_W-1:0]   tx_data_q, tx_data_d;

   assign fifo_level_o = level_q;
   assign fifo_empty_o = (level_q == '0);
   assign fifo_full_o  = (level_q == LEVEL_MAX);
   assign wr_ready_o   = !fifo_full_o;
   assign busy_o       = (state_q != ST_IDLE);
   assign tx_start_o   = tx_start_q;
   assign tx_data_o    = tx_data_q;

   // Flush wins over both a same-cycle write and a launch.
   assign push = wr_valid_i && wr_ready_o && !flush_i;
   assign pop  = (state_q == ST_IDLE) && stream_en_i && !fifo_empty_o && !flush_i;

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= wr_ptr_q;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         unique case ({push, pop})
            2'b10:   level_q <= level_q + LEVEL_ONE;
            2'b01:   level_q <= level_q - LEVEL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset; the pointers define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // FSM state and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   // Next state. A done seen while still in START means the controller finished
   // without a visible busy phase, so the character is complete.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (pop) state_d = ST_START;
         ST_START: begin
            if (tx_done_i)      state_d = ST_IDLE;
            else if (tx_busy_i) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: if (tx_done_i) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs; tx_data holds between characters.
   always_comb begin
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pop) begin
               tx_start_d = 1'b1;
               tx_data_d  = mem_q[rd_ptr_q];
            end
         end
         ST_START:     tx_start_d = !(tx_done_i || tx_busy_i);
         ST_WAIT_DONE: tx_start_d = 1'b0;
         default:      tx_start_d = 1'b0;
      endcase
   end

endmodule
